// File: rtl/lsu_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_bus_ctrl
// Brief    : Single-outstanding load/store sequencer between the AGU and a
//            req/gnt/rvalid memory bus, with flush and bus timeout handling.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_bus_ctrl #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        agu_req_i,
    input  logic        agu_we_i,
    input  logic [31:0] agu_raddr_i,
    input  logic [31:0] agu_waddr_i,
    input  logic [31:0] agu_wdata_i,
    input  logic [3:0]  agu_wmask_i,
    input  logic        flush_i,
    output logic        agu_ready_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_wmask_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic        rsp_valid_o,
    output logic        rsp_we_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    // Last count value before the transaction is abandoned.
    localparam logic [15:0] c_to_last = 16'(TIMEOUT_CYC - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic        r_drop;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wmask;
    logic        r_bus_req;
    logic        r_rsp_valid;
    logic        r_rsp_we;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic        w_accept;
    logic        w_complete;
    logic        w_timeout;
    logic        w_drop_set;
    logic        w_to_hit;
    logic        w_drop_eff;
    logic        w_rsp_fire;

    assign agu_ready_o = (r_state == S_IDLE) & ~flush_i;
    assign w_to_hit    = (r_cnt == c_to_last);
    assign w_drop_eff  = r_drop | w_drop_set;
    assign w_rsp_fire  = (w_complete | w_timeout) & ~w_drop_eff;

    assign busy_o      = (r_state != S_IDLE);
    assign bus_req_o   = r_bus_req;
    assign bus_we_o    = r_we;
    assign bus_addr_o  = r_addr & ~32'd3;
    assign bus_wdata_o = r_wdata;
    assign bus_wmask_o = r_wmask;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_we_o    = r_rsp_we;
    assign rsp_err_o   = r_rsp_err;
    assign rsp_rdata_o = r_rsp_rdata;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and transaction events. Completion beats timeout; a flush
    // before grant cancels silently, a flush after grant only hides the result.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        w_drop_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (agu_req_i && agu_ready_o) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_gnt_i && bus_rvalid_i) begin
                    w_complete  = 1'b1;
                    w_drop_set  = flush_i;
                    w_state_nxt = S_IDLE;
                end else if (flush_i && !bus_gnt_i) begin
                    w_state_nxt = S_IDLE;
                end else if (w_to_hit) begin
                    w_timeout   = 1'b1;
                    w_drop_set  = flush_i;
                    w_state_nxt = S_IDLE;
                end else if (bus_gnt_i) begin
                    w_drop_set  = flush_i;
                    w_state_nxt = S_RSP;
                end
            end
            S_RSP: begin
                w_drop_set = flush_i;
                if (bus_rvalid_i) begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_to_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Request capture, bus request, timeout counter, drop flag and response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 16'd0;
            r_drop      <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_wmask     <= 4'd0;
            r_bus_req   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            if (w_accept) begin
                r_we      <= agu_we_i;
                r_addr    <= agu_we_i ? agu_waddr_i : agu_raddr_i;
                r_wdata   <= agu_wdata_i;
                r_wmask   <= agu_we_i ? agu_wmask_i : 4'd0;
                r_bus_req <= 1'b1;
                r_cnt     <= 16'd0;
            end else begin
                if (r_state != S_IDLE) begin
                    r_cnt <= r_cnt + 16'd1;
                end
                if (r_state == S_REQ && w_state_nxt != S_REQ) begin
                    r_bus_req <= 1'b0;
                end
            end

            if (w_state_nxt == S_IDLE) begin
                r_drop <= 1'b0;
            end else begin
                r_drop <= w_drop_eff;
            end

            r_rsp_valid <= w_rsp_fire;
            r_rsp_err   <= w_rsp_fire & w_timeout;
            if (w_rsp_fire) begin
                r_rsp_we <= r_we;
            end
            if (w_complete && !w_drop_eff && !r_we) begin
                r_rsp_rdata <= bus_rdata_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_bus_ctrl
// Brief    : Directed plus randomized transactions for lsu_bus_ctrl, checked
//            against a transaction-level outcome model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_bus_ctrl;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        agu_req_i = 1'b0;
    logic        agu_we_i = 1'b0;
    logic [31:0] agu_raddr_i = 32'd0;
    logic [31:0] agu_waddr_i = 32'd0;
    logic [31:0] agu_wdata_i = 32'd0;
    logic [3:0]  agu_wmask_i = 4'd0;
    logic        flush_i = 1'b0;
    logic        agu_ready_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_wmask_o;
    logic        bus_gnt_i = 1'b0;
    logic        bus_rvalid_i = 1'b0;
    logic [31:0] bus_rdata_i = 32'd0;
    logic        rsp_valid_o;
    logic        rsp_we_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        busy_o;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_rdata = 32'd0;

    always #5 clk = ~clk;

    lsu_bus_ctrl #(.TIMEOUT_CYC(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .agu_req_i    (agu_req_i),
        .agu_we_i     (agu_we_i),
        .agu_raddr_i  (agu_raddr_i),
        .agu_waddr_i  (agu_waddr_i),
        .agu_wdata_i  (agu_wdata_i),
        .agu_wmask_i  (agu_wmask_i),
        .flush_i      (flush_i),
        .agu_ready_o  (agu_ready_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_wmask_o  (bus_wmask_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_we_o     (rsp_we_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .busy_o       (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction. k counts cycles spent busy (k=0 is the first REQ cycle).
    // dg: grant cycle, dr: rvalid delay after grant, kf: flush cycle (-1 none).
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] mask, input int dg, input int dr, input int kf,
                           input logic [31:0] data);
        int kc;
        int kend;
        int req_last;
        bit rsp_exp;
        bit err_exp;
        kc = dg + dr;
        if (kf >= 0 && kf < dg && kf <= T - 1) begin
            kend    = kf;
            rsp_exp = 1'b0;
            err_exp = 1'b0;
        end else if (kc <= T - 1) begin
            kend    = kc;
            rsp_exp = !(kf >= dg && kf <= kc);
            err_exp = 1'b0;
        end else begin
            kend    = T - 1;
            rsp_exp = !(kf >= 0 && kf <= T - 1);
            err_exp = 1'b1;
        end
        req_last = (dg < kend) ? dg : kend;

        step();
        chk("idle_ready", 32'(agu_ready_o), 32'd1);
        chk("idle_busy", 32'(busy_o), 32'd0);
        agu_req_i   = 1'b1;
        agu_we_i    = we;
        agu_raddr_i = we ? $urandom : addr;
        agu_waddr_i = we ? addr : $urandom;
        agu_wdata_i = wdata;
        agu_wmask_i = mask;

        for (int k = 0; k <= kend; k++) begin
            step();
            chk("busy", 32'(busy_o), 32'd1);
            chk("ready_busy", 32'(agu_ready_o), 32'd0);
            chk("rsp_quiet", 32'(rsp_valid_o), 32'd0);
            chk("bus_req", 32'(bus_req_o), 32'(k <= req_last));
            if (k <= req_last) begin
                chk("bus_addr", bus_addr_o, {addr[31:2], 2'b00});
                chk("bus_we", 32'(bus_we_o), 32'(we));
                chk("bus_wdata", bus_wdata_o, wdata);
                chk("bus_wmask", 32'(bus_wmask_o), we ? 32'(mask) : 32'd0);
            end
            agu_req_i    = 1'($urandom_range(0, 1));
            agu_we_i     = 1'($urandom_range(0, 1));
            agu_raddr_i  = $urandom;
            agu_waddr_i  = $urandom;
            agu_wdata_i  = $urandom;
            agu_wmask_i  = 4'($urandom);
            bus_gnt_i    = (k == dg);
            bus_rvalid_i = (k == kc) || (k < dg && $urandom_range(0, 3) == 0);
            bus_rdata_i  = (k == kc) ? data : $urandom;
            flush_i      = (k == kf);
        end

        step();
        agu_req_i    = 1'b0;
        bus_gnt_i    = 1'b0;
        flush_i      = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = $urandom;
        #1;
        chk("done_busy", 32'(busy_o), 32'd0);
        chk("done_ready", 32'(agu_ready_o), 32'd1);
        chk("rsp_valid", 32'(rsp_valid_o), 32'(rsp_exp));
        if (rsp_exp) begin
            chk("rsp_we", 32'(rsp_we_o), 32'(we));
            chk("rsp_err", 32'(rsp_err_o), 32'(err_exp));
        end
        if (rsp_exp && !err_exp && !we) exp_rdata = data;
        chk("rsp_rdata", rsp_rdata_o, exp_rdata);

        step();
        bus_rvalid_i = 1'b0;
        chk("rsp_pulse_end", 32'(rsp_valid_o), 32'd0);
        chk("rdata_hold", rsp_rdata_o, exp_rdata);
        chk("late_idle_req", 32'(bus_req_o), 32'd0);
    endtask

    initial begin
        int dg;
        int dr;
        int kf;

        step();
        step();
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_bus_req", 32'(bus_req_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rdata", rsp_rdata_o, 32'd0);
        chk("rst_addr", bus_addr_o, 32'd0);
        rst = 1'b0;

        // Load with grant in first REQ cycle, data next cycle.
        run_txn(1'b0, 32'h0000_1006, 32'h0, 4'h0, 0, 1, -1, 32'hDEAD_BEEF);
        // Store with grant delayed three cycles.
        run_txn(1'b1, 32'h0000_0020, 32'hABCD_0000, 4'b1100, 3, 1, -1, 32'h0);
        // Flush before grant.
        run_txn(1'b0, 32'h0000_0040, 32'h0, 4'h0, 5, 1, 1, 32'h1111_2222);
        // Flush while waiting for rvalid, rvalid two cycles later.
        run_txn(1'b0, 32'h0000_0044, 32'h0, 4'h0, 0, 3, 1, 32'h3333_4444);
        // Grant never arrives: timeout.
        run_txn(1'b0, 32'h0000_0048, 32'h0, 4'h0, 100, 0, -1, 32'h5555_6666);
        // Same-cycle grant and rvalid.
        run_txn(1'b0, 32'h0000_0050, 32'h0, 4'h0, 0, 0, -1, 32'h7777_8888);

        // Reset in REQ of a second load.
        step();
        agu_req_i   = 1'b1;
        agu_we_i    = 1'b0;
        agu_raddr_i = 32'h0000_0060;
        step();
        agu_req_i = 1'b0;
        chk("rst2_req", 32'(bus_req_o), 32'd1);
        rst = 1'b1;
        step();
        chk("rst2_bus_req", 32'(bus_req_o), 32'd0);
        chk("rst2_busy", 32'(busy_o), 32'd0);
        chk("rst2_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst2_rdata", rsp_rdata_o, 32'd0);
        chk("rst2_addr", bus_addr_o, 32'd0);
        rst = 1'b0;
        exp_rdata = 32'd0;

        for (int i = 0; i < 40; i++) begin
            dg = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
            dr = int'($urandom_range(0, 4));
            kf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                    dg, dr, kf, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
